// File: rtl/slave_region_dtack_if.sv
// Local-bus slave-cycle signals shared by the bus master and the DTACK generator.
// Latency: none, wires only.
// Backpressure: none; dtack is the only response and the master waits for it.
interface slave_region_dtack_if #(
  parameter int ADDR_W = 28
);
  logic [ADDR_W-1:0] ADDR;
  logic              READ;
  logic              FCS_n;
  logic              slave_cycle;
  logic              dtack;

  modport master (output ADDR, output READ, output FCS_n, output slave_cycle, input dtack);
  modport slave  (input ADDR, input READ, input FCS_n, input slave_cycle, output dtack);
endinterface

// File: rtl/slave_region_dtack.sv
// Region decoder and DTACK generator for slave cycles, with per-region wait states and a watchdog.
// Latency: dtack rises N+1 edges after the start edge (N = selected wait count) and falls one edge after FCS_n rises.
// Backpressure: the master holds FCS_n low until dtack; the watchdog drops dtack if the cycle never ends.
module slave_region_dtack #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 28,
  parameter int TAG_W       = 5,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  slave_region_dtack_if.slave           bus,
  input  logic                          configured,
  input  logic [NUM_REGIONS*TAG_W-1:0]  region_lo,
  input  logic [NUM_REGIONS*TAG_W-1:0]  region_hi,
  input  logic [NUM_REGIONS*WAIT_W-1:0] rd_wait,
  input  logic [NUM_REGIONS*WAIT_W-1:0] wr_wait,
  output logic [NUM_REGIONS-1:0]        region_sel,
  output logic                          busy,
  output logic                          timeout_err
);

  // Watchdog needs at least one bit even when disabled.
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } state_t;

  state_t                 state;
  logic [WAIT_W-1:0]      cnt;
  logic [WD_W-1:0]        wd;

  logic [TAG_W-1:0]       tag;
  logic [NUM_REGIONS-1:0] hit_sel;
  logic [WAIT_W-1:0]      load_cnt;
  logic                   any_hit;
  logic                   start;

  assign tag   = bus.ADDR[ADDR_W-1 -: TAG_W];
  assign start = !bus.FCS_n && bus.slave_cycle && configured && any_hit;

  // Priority decode: scan from the top so the lowest matching region is the one that sticks.
  always_comb begin
    hit_sel  = '0;
    load_cnt = '0;
    any_hit  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((region_lo[i*TAG_W +: TAG_W] < region_hi[i*TAG_W +: TAG_W]) &&
          (tag >= region_lo[i*TAG_W +: TAG_W]) &&
          (tag <  region_hi[i*TAG_W +: TAG_W])) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        any_hit    = 1'b1;
        load_cnt   = bus.READ ? rd_wait[i*WAIT_W +: WAIT_W] : wr_wait[i*WAIT_W +: WAIT_W];
      end
    end
  end

  // Cycle FSM with registered dtack/region_sel/busy/timeout_err; an FCS_n release always beats a
  // same-edge wait expiry or watchdog expiry.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state       <= S_IDLE;
      bus.dtack   <= 1'b0;
      region_sel  <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      wd          <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_WAIT;
            region_sel <= hit_sel;
            cnt        <= load_cnt;
            busy       <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.FCS_n) begin
            state      <= S_IDLE;
            region_sel <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
          end else if (cnt == '0) begin
            state     <= S_ACK;
            bus.dtack <= 1'b1;
            wd        <= WD_W'(1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACK: begin
          if (bus.FCS_n) begin
            state      <= S_IDLE;
            bus.dtack  <= 1'b0;
            region_sel <= '0;
            busy       <= 1'b0;
            wd         <= '0;
          end else if ((TIMEOUT != 0) && (wd == WD_LIMIT)) begin
            state       <= S_RECOVER;
            bus.dtack   <= 1'b0;
            timeout_err <= 1'b1;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        S_RECOVER: begin
          // Hold off until the stuck cycle really ends so it is never acknowledged twice.
          if (bus.FCS_n) begin
            state      <= S_IDLE;
            region_sel <= '0;
            busy       <= 1'b0;
            wd         <= '0;
          end
        end
        default: begin
          state      <= S_IDLE;
          bus.dtack  <= 1'b0;
          region_sel <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_region_dtack.sv
module tb_slave_region_dtack;
  localparam int NR  = 4;
  localparam int AW  = 24;
  localparam int TW  = 8;
  localparam int WW  = 4;
  localparam int TMO = 8;

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  always #5 CLK = ~CLK;

  slave_region_dtack_if #(.ADDR_W(AW)) bus ();

  logic              configured;
  logic [NR*TW-1:0]  region_lo, region_hi;
  logic [NR*WW-1:0]  rd_wait, wr_wait;
  logic [NR-1:0]     region_sel;
  logic              busy, timeout_err;

  slave_region_dtack #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .TAG_W(TW), .WAIT_W(WW), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus), .configured(configured),
    .region_lo(region_lo), .region_hi(region_hi), .rd_wait(rd_wait), .wr_wait(wr_wait),
    .region_sel(region_sel), .busy(busy), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Tracks one cycle as timestamps: start edge, acknowledge edge, watchdog edge.
  int          ec = 0;
  bit          act = 1'b0;
  int          ack_e, tmo_e, hidx, nwait;
  logic [NR-1:0] m_sel;
  logic        e_dtack, e_busy, e_err;
  logic [NR-1:0] e_sel;
  bit          model_ok = 1'b0;

  function automatic int first_hit(input logic [AW-1:0] a);
    logic [TW-1:0] t;
    logic [TW-1:0] lo, hi;
    t = a[AW-1 -: TW];
    for (int i = 0; i < NR; i++) begin
      lo = region_lo[i*TW +: TW];
      hi = region_hi[i*TW +: TW];
      if (lo < hi && t >= lo && t < hi) return i;
    end
    return -1;
  endfunction

  always @(posedge CLK) begin
    ec++;
    if (!RESET_n) begin
      act      = 1'b0;
      model_ok = 1'b1;
    end else if (!act) begin
      hidx = first_hit(bus.ADDR);
      if (!bus.FCS_n && bus.slave_cycle && configured && hidx >= 0) begin
        act   = 1'b1;
        nwait = bus.READ ? int'(rd_wait[hidx*WW +: WW]) : int'(wr_wait[hidx*WW +: WW]);
        ack_e = ec + nwait + 1;
        tmo_e = ack_e + TMO;
        m_sel = NR'(1) << hidx;
      end
    end else if (bus.FCS_n) begin
      act = 1'b0;
    end
    if (act) begin
      e_busy  = 1'b1;
      e_sel   = m_sel;
      e_dtack = (ec >= ack_e) && (TMO == 0 || ec < tmo_e);
      e_err   = (TMO != 0) && (ec == tmo_e);
    end else begin
      e_busy  = 1'b0;
      e_sel   = '0;
      e_dtack = 1'b0;
      e_err   = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      chk("m_dtack", 32'(bus.dtack), 32'(e_dtack));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_region_sel", 32'(region_sel), 32'(e_sel));
      chk("m_timeout_err", 32'(timeout_err), 32'(e_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic set_region(input int i, input int lo, input int hi, input int rw, input int ww);
    region_lo[i*TW +: TW] = TW'(lo);
    region_hi[i*TW +: TW] = TW'(hi);
    rd_wait[i*WW +: WW]   = WW'(rw);
    wr_wait[i*WW +: WW]   = WW'(ww);
  endtask

  task automatic start(input logic [AW-1:0] a, input logic rd);
    bus.ADDR  = a;
    bus.READ  = rd;
    bus.FCS_n = 1'b0;
  endtask

  task automatic release_bus();
    bus.FCS_n = 1'b1;
    tick(2);
  endtask

  initial begin
    bus.ADDR = '0; bus.READ = 1'b1; bus.FCS_n = 1'b1; bus.slave_cycle = 1'b1;
    configured = 1'b1;
    region_lo = '0; region_hi = '0; rd_wait = '0; wr_wait = '0;
    RESET_n = 1'b0;
    tick(2);
    chk("rst_dtack", 32'(bus.dtack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(region_sel), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    RESET_n = 1'b1;
    tick(1);

    // Region 0 read, one wait state: dtack at E0+2.
    set_region(0, 'h08, 'h48, 1, 0);
    start(24'h400000, 1'b1);
    tick(1);
    chk("r0_sel", 32'(region_sel), 32'b0001);
    chk("r0_busy", 32'(busy), 32'd1);
    chk("r0_dtack_e0", 32'(bus.dtack), 32'd0);
    tick(1);
    chk("r0_dtack_e1", 32'(bus.dtack), 32'd0);
    tick(1);
    chk("r0_dtack_e2", 32'(bus.dtack), 32'd1);
    bus.FCS_n = 1'b1;
    tick(1);
    chk("r0_release", 32'(bus.dtack), 32'd0);
    chk("r0_idle", 32'(busy), 32'd0);
    tick(1);

    // Region 1: write waits 3, read waits 0.
    set_region(1, 'h50, 'h60, 0, 3);
    start(24'h550000, 1'b0);
    tick(4);
    chk("r1_wr_e3", 32'(bus.dtack), 32'd0);
    tick(1);
    chk("r1_wr_e4", 32'(bus.dtack), 32'd1);
    chk("r1_sel", 32'(region_sel), 32'b0010);
    release_bus();
    start(24'h550000, 1'b1);
    tick(1);
    chk("r1_rd_e0", 32'(bus.dtack), 32'd0);
    tick(1);
    chk("r1_rd_e1", 32'(bus.dtack), 32'd1);
    release_bus();

    // Overlap of regions 0 and 2: lowest index wins.
    set_region(2, 'h30, 'h50, 2, 2);
    start(24'h400000, 1'b1);
    tick(1);
    chk("ovl_sel", 32'(region_sel), 32'b0001);
    tick(2);
    chk("ovl_dtack", 32'(bus.dtack), 32'd1);
    release_bus();

    // Disabled region (lo == hi) must never respond.
    set_region(0, 'h20, 'h48, 1, 0);
    set_region(3, 'h10, 'h10, 0, 0);
    start(24'h100000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("dis_busy", 32'(busy), 32'd0);
      chk("dis_dtack", 32'(bus.dtack), 32'd0);
    end
    release_bus();
    set_region(0, 'h08, 'h48, 1, 0);

    // Abort during a 5-cycle wait: FCS_n high sampled at E0+3.
    set_region(3, 'h70, 'h80, 5, 5);
    start(24'h700000, 1'b1);
    tick(3);
    bus.FCS_n = 1'b1;
    tick(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dtack", 32'(bus.dtack), 32'd0);
    tick(5);

    // FCS_n release on the same edge the wait count expires: abort wins.
    start(24'h400000, 1'b1);
    tick(2);
    bus.FCS_n = 1'b1;
    tick(1);
    chk("race_abort_dtack", 32'(bus.dtack), 32'd0);
    chk("race_abort_busy", 32'(busy), 32'd0);
    tick(1);

    // Watchdog: 8 cycles of dtack, one-cycle error, no re-acknowledge while stuck.
    set_region(0, 'h08, 'h48, 0, 0);
    start(24'h400000, 1'b1);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("wd_dtack_hold", 32'(bus.dtack), 32'd1);
      chk("wd_err_quiet", 32'(timeout_err), 32'd0);
    end
    tick(1);
    chk("wd_dtack_drop", 32'(bus.dtack), 32'd0);
    chk("wd_err_pulse", 32'(timeout_err), 32'd1);
    chk("wd_busy", 32'(busy), 32'd1);
    chk("wd_sel_kept", 32'(region_sel), 32'b0001);
    tick(1);
    chk("wd_err_once", 32'(timeout_err), 32'd0);
    tick(3);
    chk("wd_no_reack", 32'(bus.dtack), 32'd0);
    bus.FCS_n = 1'b1;
    tick(1);
    chk("wd_recover_idle", 32'(busy), 32'd0);
    bus.FCS_n = 1'b0;
    tick(1);
    chk("fresh_e0", 32'(bus.dtack), 32'd0);
    tick(1);
    chk("fresh_ack", 32'(bus.dtack), 32'd1);
    release_bus();

    // Release on the same edge the watchdog would fire: no error.
    start(24'h400000, 1'b1);
    tick(9);
    chk("wdrace_pre", 32'(bus.dtack), 32'd1);
    bus.FCS_n = 1'b1;
    tick(1);
    chk("wdrace_dtack", 32'(bus.dtack), 32'd0);
    chk("wdrace_err", 32'(timeout_err), 32'd0);
    chk("wdrace_busy", 32'(busy), 32'd0);
    tick(1);

    // Reset while acknowledging.
    start(24'h400000, 1'b1);
    tick(3);
    chk("rstack_pre", 32'(bus.dtack), 32'd1);
    RESET_n = 1'b0;
    tick(1);
    chk("rstack_dtack", 32'(bus.dtack), 32'd0);
    chk("rstack_sel", 32'(region_sel), 32'd0);
    chk("rstack_busy", 32'(busy), 32'd0);
    RESET_n = 1'b1;
    bus.FCS_n = 1'b1;
    tick(2);

    // Not configured: nothing responds.
    configured = 1'b0;
    foreach (region_sel[i]) begin
      start(AW'(i == 0 ? 'h400000 : i == 1 ? 'h550000 : i == 2 ? 'h700000 : 'h100000), 1'b1);
      tick(3);
      chk("unconf_busy", 32'(busy), 32'd0);
      chk("unconf_dtack", 32'(bus.dtack), 32'd0);
      bus.FCS_n = 1'b1;
      tick(1);
    end
    configured = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/slave_region_dtack.md
# slave_region_dtack

Parametrised slave-cycle region decoder and DTACK generator for the card's local bus. It decodes up to NUM_REGIONS address windows and applies per-region, per-direction wait states before asserting DTACK. A watchdog releases DTACK if the master never ends the cycle. It sits beside the Zorro slave-cycle logic and drives the DTACK mux for all BAR sub-regions, including SCSI, ROM and registers.

## Interface
- NUM_REGIONS, 4: number of decoded windows (1..8).
- ADDR_W, 28: address width.
- TAG_W, 5: upper address bits compared, ADDR[ADDR_W-1 -: TAG_W].
- WAIT_W, 4: width of each wait-state count.
- TIMEOUT, 255: maximum DTACK hold cycles; 0 disables the watchdog.
- CLK  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  synchronous, active-low reset.
- ADDR  in  ADDR_W  bus address.
- READ  in  1  1 = read, 0 = write.
- FCS_n  in  1  full cycle strobe, active low.
- slave_cycle  in  1  cycle targets this card.
- configured  in  1  autoconfig complete.
- region_lo  in  NUM_REGIONS*TAG_W  inclusive lower tag per region (region i at [i*TAG_W +: TAG_W]).
- region_hi  in  NUM_REGIONS*TAG_W  exclusive upper tag per region.
- rd_wait  in  NUM_REGIONS*WAIT_W  read wait states per region.
- wr_wait  in  NUM_REGIONS*WAIT_W  write wait states per region.
- dtack  out  1  registered acknowledge.
- region_sel  out  NUM_REGIONS  one-hot latched region of the current cycle.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Hit for region i: lo_i <= tag < hi_i. lo_i >= hi_i disables the region. On overlap, the lowest index wins.
- Start condition: !FCS_n && slave_cycle && configured && any hit. It is evaluated only in IDLE.
- IDLE: dtack=0, region_sel=0. On start, latch the one-hot region and load cnt = READ ? rd_wait[i] : wr_wait[i], then go to WAIT. ADDR, READ and the config inputs are ignored after the latch.
- WAIT: if FCS_n=1, abort to IDLE with no dtack. Else if cnt==0, go to ACK with dtack=1 at the same edge. Else decrement cnt.
- ACK: dtack=1. The watchdog counts from 1 each cycle. If FCS_n=1, go to IDLE with dtack=0 at that edge. Else if TIMEOUT!=0 and the watchdog reaches TIMEOUT, go to RECOVER with dtack=0 and timeout_err=1 for that one cycle.
- RECOVER: dtack=0. Wait for FCS_n=1, then go to IDLE. This prevents re-acknowledging a stuck cycle.
- busy=1 in WAIT, ACK and RECOVER. region_sel holds its value from the latch until the FSM returns to IDLE, including in RECOVER.
- No hit while FCS_n is low: stay in IDLE. dtack is never asserted, and another responder or the bus timeout handles the cycle.
- Watchdog width is clog2(TIMEOUT+1) and it saturates. cnt width is WAIT_W. Wait values are unsigned, so 0..2^WAIT_W-1.

## Timing
- Reset, synchronous and dominant over all other inputs: FSM=IDLE, dtack=0, region_sel=0, busy=0, timeout_err=0, counters=0. Reset mid-cycle drops dtack at the next edge.
- Let E0 be the edge that samples the start condition. With wait count N, dtack rises at edge E0+N+1. N=1 reproduces the legacy 2-edge SCSI acknowledge.
- dtack falls at the first edge that samples FCS_n=1 in ACK.
- Back-to-back cycles: at least one IDLE cycle between ACK exit and the next latch. The earliest next E0 is the edge after the FSM returns to IDLE.
- FCS_n rising on the same edge that cnt hits 0: abort wins, and no dtack is produced.
- FCS_n rising on the same edge the watchdog expires: normal release wins, with no timeout_err.
- A change to region_lo, region_hi or the wait inputs during a cycle affects only the next cycle.

## Test plan
- Region 0 tags [0x08,0x48), rd_wait=1. Read at ADDR=0x0400000 with FCS_n held low -> dtack=1 at E0+2, region_sel=0001. FCS_n high -> dtack=0 on the next edge.
- Region 1 with wr_wait=3, rd_wait=0. A write gives dtack at E0+4; a read gives dtack at E0+1.
- Overlapping regions 0 and 2 both hit -> region_sel=0001. A disabled region (lo=hi=0x10) at tag 0x10 -> no dtack, busy stays 0.
- Wait=5 with FCS_n deasserted at E0+3 -> no dtack pulse, FSM back in IDLE, busy=0 after the abort edge.
- TIMEOUT=8 with FCS_n held low -> dtack high for 8 cycles, then dtack=0, timeout_err high for exactly 1 cycle, no re-assert while FCS_n stays low. FCS_n high then low again -> a fresh acknowledge.
- RESET_n low for one edge while in ACK -> dtack=0, region_sel=0, busy=0 on that edge. configured=0 -> no response to any address.
